// File: rtl/gpr_pkg.sv
// Shared constants and types for the integer register file of myCPU.
package gpr_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0]    gpr_addr_t;
  typedef logic [XLEN-1:0]      gpr_data_t;
  typedef logic [NREG*XLEN-1:0] gpr_flat_t;

  // A retiring instruction updates architectural state only when it writes a non-x0 register.
  function automatic logic wb_writes(input logic valid, input logic wen, input gpr_addr_t rd);
    return valid && wen && (rd != '0);
  endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port: index mux over the flat state bus, x0 forced to zero,
// and an optional same-cycle write-through selected by the parent.
module gpr_read_port
  import gpr_pkg::*;
(
  input  gpr_flat_t regs_flat,
  input  gpr_addr_t rd_addr,
  input  logic      byp_hit,
  input  gpr_data_t byp_data,
  output gpr_data_t rd_data
);

  gpr_data_t stored;

  always_comb begin
    stored = regs_flat[XLEN*rd_addr +: XLEN];
    if (rd_addr == '0) begin
      rd_data = '0;
    end else if (byp_hit) begin
      rd_data = byp_data;
    end else begin
      rd_data = stored;
    end
  end

endmodule

// File: rtl/gpr_file.sv
// Architectural register file with commit pulse, commit PC and retired-instruction counter.
// Optional write-through read bypass enabled by defining GPR_FILE_BYPASS_EN.
module gpr_file
  import gpr_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    rs1_addr,
  output logic [XLEN-1:0]      rs1_data,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 wb_valid,
  input  logic                 wb_wen,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [XLEN-1:0]      wb_pc,
  output logic [NREG*XLEN-1:0] regfile_flat,
  output logic                 commit_valid,
  output logic [XLEN-1:0]      commit_pc,
  output logic [63:0]          instret
);

  // Handshake: wb_valid marks exactly one retiring instruction per cycle and qualifies
  // wb_wen/wb_rd/wb_data/wb_pc; there is no backpressure. commit_valid is wb_valid delayed
  // one cycle and qualifies commit_pc, by which time regfile_flat already holds the write.

  gpr_data_t regs_q [1:NREG-1];
  gpr_data_t regs_d [1:NREG-1];
  logic      commit_valid_q, commit_valid_d;
  gpr_data_t commit_pc_q, commit_pc_d;
  logic [63:0] instret_q, instret_d;
  logic      wr_hit;
  logic      byp1_hit, byp2_hit;

  always_comb begin
    wr_hit = wb_writes(wb_valid, wb_wen, wb_rd);
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit && (wb_rd == ADDR_W'(i))) begin
        regs_d[i] = wb_data;
      end
    end
    commit_valid_d = wb_valid;
    commit_pc_d    = wb_valid ? wb_pc : commit_pc_q;
    instret_d      = wb_valid ? instret_q + 64'd1 : instret_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      instret_q      <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      instret_q      <= instret_d;
    end
  end

  // Slice 0 is tied off: x0 has no storage.
  always_comb begin
    regfile_flat = '0;
    for (int i = 1; i < NREG; i++) begin
      regfile_flat[XLEN*i +: XLEN] = regs_q[i];
    end
  end

`ifdef GPR_FILE_BYPASS_EN
  assign byp1_hit = wr_hit && (rs1_addr == wb_rd);
  assign byp2_hit = wr_hit && (rs2_addr == wb_rd);
`else
  assign byp1_hit = 1'b0;
  assign byp2_hit = 1'b0;
`endif

  gpr_read_port u_rs1 (
    .regs_flat (regfile_flat),
    .rd_addr   (rs1_addr),
    .byp_hit   (byp1_hit),
    .byp_data  (wb_data),
    .rd_data   (rs1_data)
  );

  gpr_read_port u_rs2 (
    .regs_flat (regfile_flat),
    .rd_addr   (rs2_addr),
    .byp_hit   (byp2_hit),
    .byp_data  (wb_data),
    .rd_data   (rs2_data)
  );

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: commits are scoreboarded through an expected queue,
// combinational reads and reset behaviour are checked inline.
module tb_gpr_file;
  import gpr_pkg::*;

  localparam int EW = XLEN + 64 + ADDR_W + XLEN + 1;

  logic                 clock;
  logic                 reset;
  logic [ADDR_W-1:0]    rs1_addr, rs2_addr;
  logic [XLEN-1:0]      rs1_data, rs2_data;
  logic                 wb_valid, wb_wen;
  logic [ADDR_W-1:0]    wb_rd;
  logic [XLEN-1:0]      wb_data, wb_pc;
  logic [NREG*XLEN-1:0] regfile_flat;
  logic                 commit_valid;
  logic [XLEN-1:0]      commit_pc;
  logic [63:0]          instret;

  int tests_run    = 0;
  int tests_failed = 0;
  int commits_seen = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0]   exp_instret;
  logic [63:0]   acc;
  logic [63:0]   byp_exp;

  gpr_file dut (
    .clock        (clock),
    .reset        (reset),
    .rs1_addr     (rs1_addr),
    .rs1_data     (rs1_data),
    .rs2_addr     (rs2_addr),
    .rs2_data     (rs2_data),
    .wb_valid     (wb_valid),
    .wb_wen       (wb_wen),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_pc        (wb_pc),
    .regfile_flat (regfile_flat),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .instret      (instret)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] slice(input int i);
    return regfile_flat[XLEN*i +: XLEN];
  endfunction

  function automatic logic [63:0] flat_or();
    logic [63:0] r = '0;
    for (int i = 0; i < NREG; i++) r |= slice(i);
    return r;
  endfunction

  // Driver: apply one writeback at the negedge, push its expected commit
  task automatic drive(input logic w, input logic [ADDR_W-1:0] rd,
                       input logic [63:0] d, input logic [63:0] pc);
    @(negedge clock);
    wb_valid = 1'b1;
    wb_wen   = w;
    wb_rd    = rd;
    wb_data  = d;
    wb_pc    = pc;
    exp_instret = exp_instret + 64'd1;
    exp_q.push_back({pc, exp_instret, rd, (w && rd != '0) ? d : 64'd0, w});
  endtask

  task automatic idle();
    @(negedge clock);
    wb_valid = 1'b0;
    wb_wen   = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset === 1'b1 && commit_valid === 1'b1) begin
      commits_seen++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_commit: got commit_pc 0x%h expected no commit", commit_pc);
      end else begin
        e = exp_q.pop_front();
        check("commit_pc", commit_pc, e[EW-1 -: 64]);
        check("commit_instret", instret, e[EW-65 -: 64]);
        if (e[0]) check("commit_flat_slice", slice(int'(e[XLEN+ADDR_W:XLEN+1])), e[XLEN:1]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd5; wb_data = '1; wb_pc = 64'h100;
    rs1_addr = '0; rs2_addr = '0;
    exp_instret = '0;

    // Reset held while a write is presented
    repeat (3) @(posedge clock);
    #1;
    check("reset_flat", flat_or(), 64'd0);
    check("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_commit_pc", commit_pc, 64'd0);
    @(negedge clock);
    reset = 1'b1; wb_valid = 1'b0; wb_wen = 1'b0;

    // Write x5 and read it back
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 64'h8000_0000);
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    #1;
    check("rs1_x5", rs1_data, 64'hDEAD_BEEF_0000_0001);
    check("rs2_x5_same_reg", rs2_data, 64'hDEAD_BEEF_0000_0001);
    check("flat_x5", slice(5), 64'hDEAD_BEEF_0000_0001);
    idle();
    #1;
    check("commit_pulse_low", {63'd0, commit_valid}, 64'd0);
    check("commit_pc_hold", commit_pc, 64'h8000_0000);

    // Write to x0 is dropped but still retires
    drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0004);
    idle();
    rs2_addr = 5'd0;
    #1;
    check("rs2_x0", rs2_data, 64'd0);
    check("flat_x0", slice(0), 64'd0);
    check("instret_after_x0", instret, 64'd2);

    // wb_wen without wb_valid is ignored
    @(negedge clock);
    wb_valid = 1'b0; wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 64'h5555;
    idle();
    rs1_addr = 5'd9;
    #1;
    check("wen_no_valid", rs1_data, 64'd0);

    // Same-cycle write and read of x7
    drive(1'b1, 5'd7, 64'h1234, 64'h8000_0008);
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
`ifdef GPR_FILE_BYPASS_EN
    byp_exp = 64'h1234;
`else
    byp_exp = 64'h0;
`endif
    #1;
    check("rs1_same_cycle_x7", rs1_data, byp_exp);
    check("rs2_same_cycle_x7", rs2_data, byp_exp);
    check("flat_not_bypassed", slice(7), 64'd0);
    idle();
    #1;
    check("rs1_x7_stored", rs1_data, 64'h1234);

    // Clean reset before streaming
    @(negedge clock);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    exp_instret = '0;
    #1;
    check("reset_clears_x5", slice(5), 64'd0);

    // Streaming: ten back-to-back commits writing x1..x10
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ADDR_W'(i + 1), 64'h1000 + 64'(i), 64'h8000_0000 + 64'(4 * i));
    end
    idle();
    #1;
    check("stream_instret", instret, 64'd10);
    check("stream_commit_pc", commit_pc, 64'h8000_0024);
    idle();
    #1;
    check("stream_end_low", {63'd0, commit_valid}, 64'd0);
    check("stream_pc_hold", commit_pc, 64'h8000_0024);

    // Counter wrap
    @(negedge clock);
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    #1;
    check("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_instret = '1;
    drive(1'b0, 5'd0, 64'd0, 64'h9000);
    idle();
    #1;
    check("instret_wrap", instret, 64'd0);

    // Async reset in the middle of a stream
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd10, 64'hA000 + 64'(i), 64'hA000_0000 + 64'(4 * i));
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_commit_valid", {63'd0, commit_valid}, 64'd0);
    check("async_instret", instret, 64'd0);
    check("async_commit_pc", commit_pc, 64'd0);
    check("async_flat", flat_or(), 64'd0);
    exp_q.delete();
    @(negedge clock);
    wb_valid = 1'b0; wb_wen = 1'b0;
    reset = 1'b1;
    exp_instret = '0;

    idle();
    idle();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("commit_count", 64'(commits_seen), 64'd18);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
